// File: rtl/mem_pkg.sv
// Shared types and default geometry for the byte-enabled memory array.
package mem_pkg;

  localparam int unsigned DefaultDataW = 32;
  localparam int unsigned DefaultDepth = 16;

  typedef enum logic [0:0] {
    IDLE,
    CLEAR
  } mem_state_e;

endpackage

// File: rtl/memory_word_be.sv
// One storage word: DATA_W register with per-byte write enables and a synchronous clear.
module memory_word_be #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned BE_W   = DATA_W / 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              we,
  input  logic [BE_W-1:0]   be,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  logic [DATA_W-1:0] word_q, word_d;

  // Clear wins over a same-cycle write; the controller never issues both to one word.
  always_comb begin
    word_d = word_q;
    if (clr) begin
      word_d = '0;
    end else if (we) begin
      for (int unsigned i = 0; i < BE_W; i++) begin
        if (be[i]) begin
          word_d[8*i +: 8] = d[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      word_q <= '0;
    end else begin
      word_q <= word_d;
    end
  end

  assign q = word_q;

endmodule

// File: rtl/memory_array_param.sv
// Parameterised word array with byte-enabled writes, registered reads and a bulk-clear sequencer.
module memory_array_param
  import mem_pkg::*;
#(
  parameter int unsigned DATA_W = DefaultDataW,
  parameter int unsigned DEPTH  = DefaultDepth,
  parameter int unsigned ADDR_W = $clog2(DEPTH),
  parameter int unsigned BE_W   = DATA_W / 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [BE_W-1:0]   wr_be,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              clear_req,
  output logic              busy
);

  mem_state_e        state_q, state_d;
  logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;

  logic [DATA_W-1:0] word_rd [DEPTH];
  logic [DEPTH-1:0]  word_we;
  logic [DEPTH-1:0]  word_clr;
  logic [DATA_W-1:0] rd_word;
  logic              clearing;
  logic              wr_ok;

  assign clearing = (state_q == CLEAR);
  assign wr_ok    = wr_en & ~clearing;

  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    unique case (state_q)
      IDLE: begin
        if (clear_req) begin
          state_d   = CLEAR;
          clr_ptr_d = '0;
        end
      end
      CLEAR: begin
        if (clr_ptr_q == ADDR_W'(DEPTH - 1)) begin
          state_d   = IDLE;
          clr_ptr_d = '0;
        end else begin
          clr_ptr_d = clr_ptr_q + 1'b1;
        end
      end
      default: begin
        state_d   = IDLE;
        clr_ptr_d = '0;
      end
    endcase
  end

  // Addresses at or above DEPTH match no word, so such writes drop and such reads return 0.
  always_comb begin
    word_we  = '0;
    word_clr = '0;
    rd_word  = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      word_we[i]  = wr_ok && (wr_addr == ADDR_W'(i));
      word_clr[i] = clearing && (clr_ptr_q == ADDR_W'(i));
      if (rd_addr == ADDR_W'(i)) begin
        rd_word = word_rd[i];
      end
    end
  end

  // Reads sample the pre-edge word contents, giving old data on a same-address write.
  always_comb begin
    rd_valid_d = rd_en;
    rd_data_d  = rd_en ? rd_word : rd_data_q;
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_word
    memory_word_be #(
      .DATA_W(DATA_W),
      .BE_W  (BE_W)
    ) u_word (
      .clk  (clk),
      .reset(reset),
      .clr  (word_clr[g]),
      .we   (word_we[g]),
      .be   (wr_be),
      .d    (wr_data),
      .q    (word_rd[g])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      clr_ptr_q  <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_ptr_q  <= clr_ptr_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign busy     = clearing;

endmodule

// File: tb/tb_memory_array_param.sv
// Scoreboard bench: stimulus pushes expected read data, a negedge monitor pops and compares.
module tb_memory_array_param;

  typedef struct {
    logic [31:0] data;
    int          addr;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  // Default instance: DEPTH=16
  logic        wr_en, rd_en, clear_req;
  logic [3:0]  wr_addr, rd_addr, wr_be;
  logic [31:0] wr_data, rd_data;
  logic        rd_valid, busy;
  // Non-power-of-2 instance: DEPTH=12
  logic        wr_en_b, rd_en_b, clear_req_b;
  logic [3:0]  wr_addr_b, rd_addr_b, wr_be_b;
  logic [31:0] wr_data_b, rd_data_b;
  logic        rd_valid_b, busy_b;

  int   total = 0;
  int   bad = 0;
  exp_t exp_q[$];
  exp_t exp_b_q[$];

  memory_array_param #(
    .DATA_W(32),
    .DEPTH (16)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .wr_be    (wr_be),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .clear_req(clear_req),
    .busy     (busy)
  );

  memory_array_param #(
    .DATA_W(32),
    .DEPTH (12)
  ) dut_b (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (wr_en_b),
    .wr_addr  (wr_addr_b),
    .wr_data  (wr_data_b),
    .wr_be    (wr_be_b),
    .rd_en    (rd_en_b),
    .rd_addr  (rd_addr_b),
    .rd_data  (rd_data_b),
    .rd_valid (rd_valid_b),
    .clear_req(clear_req_b),
    .busy     (busy_b)
  );

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endfunction

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rd_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected rd_valid (d16): got 1 want 0");
      end else begin
        e = exp_q.pop_front();
        check($sformatf("d16 read addr %0d", e.addr), rd_data, e.data);
      end
    end
    if (rd_valid_b === 1'b1) begin
      if (exp_b_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected rd_valid (d12): got 1 want 0");
      end else begin
        e = exp_b_q.pop_front();
        check($sformatf("d12 read addr %0d", e.addr), rd_data_b, e.data);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
    wr_en = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
    step();
    wr_en = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a, input logic [31:0] e);
    rd_en = 1'b1; rd_addr = a;
    exp_q.push_back('{data: e, addr: int'(a)});
    step();
    rd_en = 1'b0;
  endtask

  task automatic wr_b(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
    wr_en_b = 1'b1; wr_addr_b = a; wr_data_b = d; wr_be_b = be;
    step();
    wr_en_b = 1'b0;
  endtask

  task automatic rd_b(input logic [3:0] a, input logic [31:0] e);
    rd_en_b = 1'b1; rd_addr_b = a;
    exp_b_q.push_back('{data: e, addr: int'(a)});
    step();
    rd_en_b = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 40) begin
      step();
      n++;
    end
  endtask

  task automatic fill16();
    for (int i = 0; i < 16; i++) wr(4'(i), 32'hC0DE_0000 | 32'(i), 4'hF);
  endtask

  initial begin
    int n;
    reset = 1'b1;
    wr_en = 0; rd_en = 0; clear_req = 0; wr_addr = 0; rd_addr = 0; wr_data = 0; wr_be = 0;
    wr_en_b = 0; rd_en_b = 0; clear_req_b = 0; wr_addr_b = 0; rd_addr_b = 0;
    wr_data_b = 0; wr_be_b = 0;
    step();
    step();
    reset = 1'b0;
    check("reset rd_valid", 32'(rd_valid), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset rd_data", rd_data, 32'd0);

    rd(4'd3, 32'h0000_0000);

    // Byte-enable merge, then an all-zero enable write that must change nothing.
    wr(4'd5, 32'hDEAD_BEEF, 4'b1111);
    wr(4'd5, 32'h1122_3344, 4'b0101);
    rd(4'd5, 32'hDE22_BE44);
    wr(4'd5, 32'hFFFF_FFFF, 4'b0000);
    rd(4'd5, 32'hDE22_BE44);

    // Same-address read/write at one edge returns old data.
    wr_en = 1'b1; wr_addr = 4'd2; wr_data = 32'hA5A5_A5A5; wr_be = 4'hF;
    rd_en = 1'b1; rd_addr = 4'd2;
    exp_q.push_back('{data: 32'h0, addr: 2});
    step();
    wr_en = 1'b0; rd_en = 1'b0;
    rd(4'd2, 32'hA5A5_A5A5);
    step();
    check("idle rd_valid low", 32'(rd_valid), 32'd0);
    check("idle rd_data held", rd_data, 32'hA5A5_A5A5);

    // Bulk clear: 16 busy cycles, reads serviced, write and re-request ignored.
    fill16();
    clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    check("busy after clear_req", 32'(busy), 32'd1);
    n = 0;
    while (busy && n < 40) begin
      case (n)
        0: begin rd_en = 1'b1; rd_addr = 4'd15; exp_q.push_back('{data: 32'hC0DE_000F, addr: 15}); end
        1: begin rd_en = 1'b1; rd_addr = 4'd0; exp_q.push_back('{data: 32'h0, addr: 0}); end
        2: begin wr_en = 1'b1; wr_addr = 4'd0; wr_data = 32'h1234_5678; wr_be = 4'hF; end
        3: clear_req = 1'b1;
        default: ;
      endcase
      step();
      n++;
      rd_en = 1'b0; wr_en = 1'b0; clear_req = 1'b0;
    end
    check("clear busy cycles", 32'(n), 32'd16);
    for (int i = 0; i < 16; i++) rd(4'(i), 32'h0);

    // Write and clear_req at the same edge: write lands, then gets erased.
    wr_en = 1'b1; wr_addr = 4'd4; wr_data = 32'h0BAD_F00D; wr_be = 4'hF; clear_req = 1'b1;
    step();
    wr_en = 1'b0; clear_req = 1'b0;
    rd(4'd4, 32'h0BAD_F00D);
    wait_idle(n);
    check("clear busy cycles 2", 32'(n), 32'd15);
    rd(4'd4, 32'h0);

    // Reset part-way through a clear aborts it and zeroes everything.
    fill16();
    clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    rd(4'd15, 32'hC0DE_000F);
    for (int i = 0; i < 5; i++) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("abort busy", 32'(busy), 32'd0);
    check("abort rd_valid", 32'(rd_valid), 32'd0);
    check("abort rd_data", rd_data, 32'd0);
    for (int i = 0; i < 16; i++) rd(4'(i), 32'h0);
    clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    check("clear after abort busy", 32'(busy), 32'd1);
    wait_idle(n);
    check("clear after abort cycles", 32'(n), 32'd16);

    // DEPTH=12: out-of-range write dropped, read returns 0 with valid.
    for (int i = 0; i < 12; i++) wr_b(4'(i), 32'h5A5A_0000 | 32'(i), 4'hF);
    wr_b(4'd13, 32'hFFFF_FFFF, 4'hF);
    rd_b(4'd13, 32'h0);
    rd_b(4'd12, 32'h0);
    for (int i = 0; i < 12; i++) rd_b(4'(i), 32'h5A5A_0000 | 32'(i));

    step();
    step();
    step();
    check("pending reads", 32'(exp_q.size() + exp_b_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/memory_array_param.md
MEMORY_ARRAY_PARAM -- requirements
Module: memory_array_param

Interface
REQ-001 Parameter DATA_W, default 32, word width in bits; SHALL be a multiple of 8.
REQ-002 Parameter DEPTH, default 16, number of words; SHALL be 2 or more.
REQ-003 Parameter ADDR_W, default $clog2(DEPTH), address width.
REQ-004 Parameter BE_W, default DATA_W/8, byte-enable width.
REQ-005 The block SHALL have one clock; reset is synchronous and active-high.
REQ-006 Port list:
  clk  in  1  rising-edge clock
  reset  in  1  synchronous active-high reset
  wr_en  in  1  write request
  wr_addr  in  ADDR_W  write address
  wr_data  in  DATA_W  write data
  wr_be  in  BE_W  byte enables, bit i covers data bits [8i+7:8i]
  rd_en  in  1  read request
  rd_addr  in  ADDR_W  read address
  rd_data  out  DATA_W  registered read data
  rd_valid  out  1  rd_data valid, one-cycle pulse per accepted read
  clear_req  in  1  start a bulk-clear sequence
  busy  out  1  clear sequence in progress

Function
REQ-007 Writes SHALL commit at the clk edge where wr_en=1 and busy=0; only bytes with wr_be[i]=1 are updated.
REQ-008 wr_en with wr_be all zero SHALL leave memory unchanged.
REQ-009 Read latency SHALL be 1 cycle: rd_en=1 at edge N gives rd_data=mem[rd_addr] and rd_valid=1 after edge N.
REQ-010 rd_valid SHALL be 0 in any cycle that follows an edge with rd_en=0; rd_data SHALL then hold its last value.
REQ-011 A read and a write to the same address at the same edge SHALL return the pre-write (old) data.
REQ-012 An address of DEPTH or greater (non-power-of-2 DEPTH) SHALL be out of range: the write is dropped, and the read returns 0 with rd_valid=1.
REQ-013 The FSM SHALL have states IDLE and CLEAR, and reset puts it in IDLE.
REQ-014 In IDLE, clear_req=1 SHALL move the FSM to CLEAR and load the clear pointer with 0.
REQ-015 In CLEAR, one word per cycle SHALL be zeroed at the pointer, and the pointer then increments.
REQ-016 After word DEPTH-1 is cleared the FSM SHALL return to IDLE, giving exactly DEPTH cycles in CLEAR.
REQ-017 busy SHALL be 1 exactly while the FSM is in CLEAR.
REQ-018 clear_req while busy=1 SHALL be ignored; it is not queued.
REQ-019 wr_en while busy=1 SHALL be dropped silently.
REQ-020 rd_en while busy=1 SHALL be serviced normally and returns current contents, which may be partially cleared.
REQ-021 clear_req and wr_en at the same edge in IDLE: the write SHALL commit, then the clear begins and erases it.

Reset
REQ-022 With reset=1 at an edge, all words, rd_data and the clear pointer SHALL be 0, rd_valid and busy SHALL be 0, and the FSM SHALL be in IDLE.
REQ-023 Reset during CLEAR SHALL abort the sequence immediately, and the REQ-022 values apply.
REQ-024 Reset SHALL take priority over every request at the same edge.

Structure
REQ-025 Package mem_pkg SHALL hold the FSM state enum (IDLE, CLEAR) and the default DATA_W and DEPTH constants.
REQ-026 Each storage word SHALL be one instance of sub-module memory_word_be: a DATA_W register with per-byte enables and a synchronous clear input.
REQ-027 Address decode, read mux, output register and FSM SHALL live in memory_array_param.

Verification
REQ-028 Reset, then read addr 3 -> rd_data=0x00000000, rd_valid=1 one cycle later.
REQ-029 Write 0xDEADBEEF to addr 5 with be=4'b1111, then write 0x11223344 with be=4'b0101, then read addr 5 -> 0xDE22BE44.
REQ-030 Write 0xA5A5A5A5 to addr 2 and read addr 2 at the same edge -> old value 0x00000000; the next read -> 0xA5A5A5A5.
REQ-031 Fill all 16 words, pulse clear_req -> busy high for exactly 16 cycles; a write to addr 0 during busy is dropped; afterwards every read returns 0.
REQ-032 Assert reset at cycle 7 of CLEAR -> busy=0 next cycle, all words read 0, and clear_req accepted again.
REQ-033 DEPTH=12: write addr 13, then read addr 13 -> rd_data=0, rd_valid=1; words 0..11 unchanged.
